multicycle_decoder: RTL and testbench

Registered control unit for the multi-cycle MIPS datapath, successor to the single-cycle opcode decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives all datapath enables, mux selects and ALU operation codes. It stalls on a memory ready handshake with a bounded timeout. Illegal opcodes and memory timeouts go to a sticky error state instead of driving X.

---
 rtl/multicycle_decoder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// multicycle_decoder
//   Registered control unit for the multi-cycle MIPS datapath. Steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath
//   enables, mux selects and ALU operation class. Memory states stall on
//   mem_ready_i, and a wait counter bounds each stall. Illegal opcodes and
//   memory timeouts land in a sticky ERROR state that only reset clears.
//
// Ports
//   clk_i, rst_i         clock, async active-high reset
//   instr_op_i           opcode from the IR, sampled only in DECODE
//   mem_ready_i          memory access completes this cycle
//   *_o (1 bit)          datapath enables / selects
//   alu_src_b_o          00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   pc_src_o             00 ALU result, 01 ALUOut, 10 jump target
//   alu_op_o             ALU operation class
//   state_o, err_o       current state, sticky error
//
// state    | enc | meaning
// FETCH    |  0  | read instruction, PC+4, wait for ready
// DECODE   |  1  | latch opcode, branch target into ALUOut
// MEM_ADDR |  2  | compute lw/sw address
// MEM_RD   |  3  | data read, wait for ready
// MEM_WB   |  4  | load result to register file
// MEM_WR   |  5  | data write, wait for ready
// R_EXEC   |  6  | R-type ALU op
// R_WB     |  7  | R-type writeback to rd
// BRANCH   |  8  | beq/bne compare and conditional PC write
// I_EXEC   |  9  | immediate ALU op
// I_WB     | 10  | immediate writeback to rt
// JUMP     | 11  | PC <- jump target
// ERROR    | 15  | sticky fault, left only by reset
module multicycle_decoder #(
  parameter int OP_W         = 6,
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               ir_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               iord_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic               is_ori_o,
  output logic               branch_ne_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_src_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [3:0]         state_o,
  output logic               err_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_I_EXEC   = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_BEQ  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_R    = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SLTI = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_ADDI = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_ORI  = ALUOP_W'(3'b111);

  localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  // Count value seen on the last tolerated not-ready cycle; one more
  // not-ready cycle here makes the count reach MEM_WAIT_MAX.
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (MEM_WAIT_MAX > 0) ? CNT_W'(MEM_WAIT_MAX - 1) : '0;

  logic [3:0]       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;
  logic             wait_state;
  logic [ALUOP_W-1:0] i_alu_op;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_cnt_d = '0;
    timeout    = (MEM_WAIT_MAX != 0) && !mem_ready_i && (wait_cnt_q == WAIT_LAST);
    wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
      end
      S_DECODE: begin
        op_d = instr_op_i;
        case (instr_op_i)
          OP_RTYPE:                            state_d = S_R_EXEC;
          OP_LW, OP_SW:                        state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_LUI, OP_ORI:    state_d = S_I_EXEC;
          OP_J:                                state_d = S_JUMP;
          default:                             state_d = S_ERROR;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i)  state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEM_WR: begin
        if (mem_ready_i)  state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase

    // Count only while stalling in place; any transition (including entry
    // into a wait state) leaves the counter at zero. Saturates at all-ones.
    if (wait_state && (state_d == state_q))
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_FETCH;
      op_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    case (op_q)
      OP_ADDI: i_alu_op = ALU_ADDI;
      OP_SLTI: i_alu_op = ALU_SLTI;
      OP_LUI:  i_alu_op = ALU_LUI;
      OP_ORI:  i_alu_op = ALU_ORI;
      default: i_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    is_ori_o        = 1'b0;
    branch_ne_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_src_o        = 2'b00;
    alu_op_o        = ALU_ADD;
    err_o           = 1'b0;
    state_o         = state_q;

    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE:   alu_src_b_o = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_R;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        alu_op_o    = ALU_R;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
        branch_ne_o     = (op_q == OP_BNE);
        alu_op_o        = (op_q == OP_BNE) ? ALU_BNE : ALU_BEQ;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = i_alu_op;
        is_ori_o    = (op_q == OP_ORI);
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
        alu_op_o    = i_alu_op;
        is_ori_o    = (op_q == OP_ORI);
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
      end
      S_ERROR: err_o = 1'b1;
      default: err_o = 1'b0;
    endcase

    // Reset is asynchronous, so outputs (including the Mealy fetch terms)
    // must be quiet for the whole time rst_i is high, not from the next edge.
    if (rst_i) begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      ir_write_o      = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      iord_o          = 1'b0;
      reg_write_o     = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      alu_src_a_o     = 1'b0;
      is_ori_o        = 1'b0;
      branch_ne_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      pc_src_o        = 2'b00;
      alu_op_o        = '0;
      err_o           = 1'b0;
      state_o         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed, table-driven bench for multicycle_decoder. Control outputs are
// packed in a fixed order and compared against hand-written constants:
// {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write,
//  reg_dst, mem_to_reg, alu_src_a, is_ori, branch_ne, alu_src_b[1:0],
//  pc_src[1:0], alu_op[2:0], err}
module tb_multicycle_decoder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o;
  logic       iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic       is_ori_o, branch_ne_o, err_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic [19:0] ctl_act;

  multicycle_decoder #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_MAX(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .ir_write_o(ir_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_src_a_o(alu_src_a_o), .is_ori_o(is_ori_o), .branch_ne_o(branch_ne_o),
    .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .state_o(state_o), .err_o(err_o)
  );

  assign ctl_act = {pc_write_o, pc_write_cond_o, ir_write_o, mem_read_o, mem_write_o,
                    iord_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
                    is_ori_o, branch_ne_o, alu_src_b_o, pc_src_o, alu_op_o, err_o};

  always #5 clk_i = ~clk_i;

  localparam logic [19:0] C_ZERO   = 20'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] C_F1     = 20'b1_0_1_1_0_0_0_0_0_0_0_0_01_00_000_0;
  localparam logic [19:0] C_F0     = 20'b0_0_0_1_0_0_0_0_0_0_0_0_01_00_000_0;
  localparam logic [19:0] C_DEC    = 20'b0_0_0_0_0_0_0_0_0_0_0_0_11_00_000_0;
  localparam logic [19:0] C_MADDR  = 20'b0_0_0_0_0_0_0_0_0_1_0_0_10_00_000_0;
  localparam logic [19:0] C_MRD    = 20'b0_0_0_1_0_1_0_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] C_MWB    = 20'b0_0_0_0_0_0_1_0_1_0_0_0_00_00_000_0;
  localparam logic [19:0] C_MWR    = 20'b0_0_0_0_1_1_0_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] C_REX    = 20'b0_0_0_0_0_0_0_0_0_1_0_0_00_00_010_0;
  localparam logic [19:0] C_RWB    = 20'b0_0_0_0_0_0_1_1_0_0_0_0_00_00_010_0;
  localparam logic [19:0] C_BEQ    = 20'b0_1_0_0_0_0_0_0_0_1_0_0_00_01_001_0;
  localparam logic [19:0] C_BNE    = 20'b0_1_0_0_0_0_0_0_0_1_0_1_00_01_101_0;
  localparam logic [19:0] C_IEX_OR = 20'b0_0_0_0_0_0_0_0_0_1_1_0_10_00_111_0;
  localparam logic [19:0] C_IWB_OR = 20'b0_0_0_0_0_0_1_0_0_0_1_0_00_00_111_0;
  localparam logic [19:0] C_IEX_AD = 20'b0_0_0_0_0_0_0_0_0_1_0_0_10_00_110_0;
  localparam logic [19:0] C_IWB_AD = 20'b0_0_0_0_0_0_1_0_0_0_0_0_00_00_110_0;
  localparam logic [19:0] C_IEX_LU = 20'b0_0_0_0_0_0_0_0_0_1_0_0_10_00_100_0;
  localparam logic [19:0] C_IWB_LU = 20'b0_0_0_0_0_0_1_0_0_0_0_0_00_00_100_0;
  localparam logic [19:0] C_JMP    = 20'b1_0_0_0_0_0_0_0_0_0_0_0_00_10_000_0;
  localparam logic [19:0] C_ERR    = 20'b0_0_0_0_0_0_0_0_0_0_0_0_00_00_000_1;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [19:0] ctl);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [19:0] ctl);
    n_vec++;
    if (state_o !== st || ctl_act !== ctl) begin
      n_err++;
      $display("FAIL %s: got state %0d ctl %b, want state %0d ctl %b",
               name, state_o, ctl_act, st, ctl);
    end
  endtask

  // Entered at posedge+1; applies inputs, checks at negedge, returns at next posedge+1.
  task automatic cycle(input string name, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [19:0] ctl);
    instr_op_i  = op;
    mem_ready_i = rdy;
    @(negedge clk_i);
    check(name, st, ctl);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst_i = 1'b1;
    #1;
    check(name, 4'd0, C_ZERO);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // add: 0,1,6,7 ; junk opcode outside DECODE must be ignored
    add(6'h3F, 1, 0, C_F1);  add(6'h00, 1, 1, C_DEC);
    add(6'h3F, 1, 6, C_REX); add(6'h3F, 0, 7, C_RWB);
    // lw with 3 not-ready cycles in MEM_RD: 8 cycles total
    add(6'h00, 1, 0, C_F1);  add(6'h23, 1, 1, C_DEC); add(6'h2B, 1, 2, C_MADDR);
    add(6'h3F, 0, 3, C_MRD); add(6'h3F, 0, 3, C_MRD); add(6'h3F, 0, 3, C_MRD);
    add(6'h3F, 1, 3, C_MRD); add(6'h3F, 0, 4, C_MWB);
    // sw zero-wait: 4 cycles
    add(6'h00, 1, 0, C_F1);  add(6'h2B, 1, 1, C_DEC); add(6'h23, 0, 2, C_MADDR);
    add(6'h00, 1, 5, C_MWR);
    // bne then beq: 3 cycles each
    add(6'h00, 1, 0, C_F1);  add(6'h05, 1, 1, C_DEC); add(6'h04, 1, 8, C_BNE);
    add(6'h00, 1, 0, C_F1);  add(6'h04, 1, 1, C_DEC); add(6'h05, 1, 8, C_BEQ);
    // ori and addi
    add(6'h00, 1, 0, C_F1);  add(6'h0D, 1, 1, C_DEC);
    add(6'h08, 1, 9, C_IEX_OR); add(6'h08, 1, 10, C_IWB_OR);
    add(6'h00, 1, 0, C_F1);  add(6'h08, 1, 1, C_DEC);
    add(6'h0D, 1, 9, C_IEX_AD); add(6'h0D, 1, 10, C_IWB_AD);
    // j
    add(6'h00, 1, 0, C_F1);  add(6'h02, 1, 1, C_DEC); add(6'h00, 1, 11, C_JMP);
    // fetch stall then lui
    add(6'h00, 0, 0, C_F0);  add(6'h00, 1, 0, C_F1);  add(6'h0F, 0, 1, C_DEC);
    add(6'h3F, 1, 9, C_IEX_LU); add(6'h3F, 1, 10, C_IWB_LU);

    instr_op_i  = 6'h00;
    mem_ready_i = 1'b1;
    rst_i       = 1'b1;
    #2;
    check("reset_outputs_zero", 4'd0, C_ZERO);
    @(posedge clk_i);
    #1;
    check("reset_held_edge", 4'd0, C_ZERO);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      cycle($sformatf("vec[%0d]", i), vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl);

    // illegal opcode: sticky ERROR regardless of inputs, until reset
    cycle("ill_fetch", 6'h00, 1, 0, C_F1);
    cycle("ill_decode", 6'h3F, 1, 1, C_DEC);
    cycle("ill_err0", 6'h00, 1, 15, C_ERR);
    cycle("ill_err1", 6'h23, 0, 15, C_ERR);
    cycle("ill_err2", 6'h00, 1, 15, C_ERR);
    do_reset("ill_reset");
    cycle("ill_after_reset", 6'h00, 0, 0, C_F0);

    // reset in MEM_RD with ready low: immediate quiet, clean restart
    cycle("rmid_fetch", 6'h00, 1, 0, C_F1);
    cycle("rmid_decode", 6'h23, 1, 1, C_DEC);
    cycle("rmid_addr", 6'h00, 0, 2, C_MADDR);
    mem_ready_i = 1'b0;
    #1;
    check("rmid_in_memrd", 4'd3, C_MRD);
    rst_i = 1'b1;
    #1;
    check("rmid_async_zero", 4'd0, C_ZERO);
    @(negedge clk_i);
    check("rmid_hold_zero", 4'd0, C_ZERO);
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rmid_edge_zero", 4'd0, C_ZERO);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    check("rmid_release", 4'd0, C_F0);
    #1;
    cycle("rmid_fetch2", 6'h00, 1, 0, C_F1);
    cycle("rmid_decode2", 6'h02, 1, 1, C_DEC);
    cycle("rmid_jump", 6'h00, 1, 11, C_JMP);

    // sw with ready never asserted: ERROR after 15 not-ready MEM_WR cycles
    cycle("to_fetch", 6'h00, 1, 0, C_F1);
    cycle("to_decode", 6'h2B, 1, 1, C_DEC);
    cycle("to_addr", 6'h00, 0, 2, C_MADDR);
    for (int i = 1; i <= 15; i++)
      cycle($sformatf("to_wait[%0d]", i), 6'h00, 0, 5, C_MWR);
    cycle("to_error", 6'h00, 1, 15, C_ERR);
    cycle("to_error_held", 6'h00, 1, 15, C_ERR);
    do_reset("to_reset");

    // ready on the 15th cycle wins over timeout
    cycle("rw_fetch", 6'h00, 1, 0, C_F1);
    cycle("rw_decode", 6'h2B, 1, 1, C_DEC);
    cycle("rw_addr", 6'h00, 0, 2, C_MADDR);
    for (int i = 1; i <= 14; i++)
      cycle($sformatf("rw_wait[%0d]", i), 6'h00, 0, 5, C_MWR);
    cycle("rw_ready15", 6'h00, 1, 5, C_MWR);
    cycle("rw_back_fetch", 6'h00, 1, 0, C_F1);
    cycle("rw_decode2", 6'h00, 1, 1, C_DEC);
    cycle("rw_rexec", 6'h00, 1, 6, C_REX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
